// File: rtl/stack_pkg.sv
// Shared types for the LIFO stack: operation encoding and decode.
package stack_pkg;

   typedef enum logic [1:0] {
      OP_NONE,
      OP_PUSH,
      OP_POP,
      OP_REPLACE
   } stack_op_e;

   function automatic stack_op_e decode_op(input logic push, input logic pop);
      stack_op_e op;
      op = OP_NONE;
      case ({push, pop})
         2'b10:   op = OP_PUSH;
         2'b01:   op = OP_POP;
         2'b11:   op = OP_REPLACE;
         default: op = OP_NONE;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/stack_mem.sv
// Stack entry storage: one write port, combinational read, no reset.
module stack_mem #(
   parameter int StackDepth = 8,
   parameter int DataWidth  = 8
) (
   input  logic                          clk,
   input  logic                          we,
   input  logic [$clog2(StackDepth)-1:0] waddr,
   input  logic [DataWidth-1:0]          wdata,
   input  logic [$clog2(StackDepth)-1:0] raddr,
   output logic [DataWidth-1:0]          rdata
);

   logic [DataWidth-1:0] mem [StackDepth];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/lifo_stack.sv
// LIFO stack with occupancy count and sticky overflow/underflow flags.
// Define STACK_WATERMARK_EN to add the high_water output.
module lifo_stack
   import stack_pkg::*;
#(
   parameter  int StackDepth = 8,
   parameter  int DataWidth  = 8,
   localparam int CountWidth = $clog2(StackDepth + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DataWidth-1:0]  data_in,
   input  logic                  err_clear,
   output logic [DataWidth-1:0]  data_out,
   output logic [CountWidth-1:0] count_out,
   output logic                  empty,
   output logic                  full,
   output logic                  overflow,
   output logic                  underflow
`ifdef STACK_WATERMARK_EN
   ,
   output logic [CountWidth-1:0] high_water
`endif
);

   localparam int AddrWidth = $clog2(StackDepth);

   stack_op_e             op;
   logic [CountWidth-1:0] count_q;
   logic [CountWidth-1:0] count_d;
   logic [AddrWidth-1:0]  top_addr;
   logic [AddrWidth-1:0]  waddr;
   logic [AddrWidth-1:0]  raddr;
   logic [DataWidth-1:0]  rdata;
   logic                  we;
   logic                  ovf_set;
   logic                  unf_set;

   assign op       = decode_op(push, pop);
   assign empty    = (count_q == '0);
   assign full     = (count_q == CountWidth'(StackDepth));
   assign top_addr = AddrWidth'(count_q - CountWidth'(1));
   // Park the read address when empty so it never leaves the array.
   assign raddr    = empty ? '0 : top_addr;
   assign data_out = empty ? '0 : rdata;
   assign count_out = count_q;

   always_comb begin
      count_d = count_q;
      we      = 1'b0;
      waddr   = AddrWidth'(count_q);
      ovf_set = 1'b0;
      unf_set = 1'b0;
      case (op)
         OP_PUSH: begin
            if (full) begin
               ovf_set = 1'b1;
            end else begin
               we      = 1'b1;
               count_d = count_q + CountWidth'(1);
            end
         end
         OP_POP: begin
            if (empty) begin
               unf_set = 1'b1;
            end else begin
               count_d = count_q - CountWidth'(1);
            end
         end
         OP_REPLACE: begin
            // Replace on an empty stack degenerates to a push into slot 0.
            we = 1'b1;
            if (empty) begin
               count_d = CountWidth'(1);
            end else begin
               waddr = top_addr;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q   <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         count_q   <= count_d;
         overflow  <= ovf_set | (overflow & ~err_clear);
         underflow <= unf_set | (underflow & ~err_clear);
      end
   end

`ifdef STACK_WATERMARK_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         high_water <= '0;
      end else if (err_clear) begin
         high_water <= count_d;
      end else if (count_d > high_water) begin
         high_water <= count_d;
      end
   end
`endif

   stack_mem #(
      .StackDepth(StackDepth),
      .DataWidth (DataWidth)
   ) u_mem (
      .clk  (clk),
      .we   (we),
      .waddr(waddr),
      .wdata(data_in),
      .raddr(raddr),
      .rdata(rdata)
   );

endmodule

// File: doc/lifo_stack.md
Name: lifo_stack

Overview:
- Parametrised LIFO stack for nested-context storage, e.g. interrupt return state on the core side.
- Generalised in width and depth.
- Adds full/empty status, an occupancy count, and sticky overflow/underflow errors.
- Adds a same-cycle push+pop "replace top" operation.
- Memory is a sub-module; control, counter and flags live in this block.

Parameters:
- StackDepth, 8, number of entries; must be >= 2.
- DataWidth, 8, bits per entry.
- CountWidth, $clog2(StackDepth+1), derived localparam; width of the occupancy count.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- push  input  1  write data_in onto the stack.
- pop  input  1  remove the top entry.
- data_in  input  DataWidth  value to push or replace with.
- err_clear  input  1  clears the sticky error flags.
- data_out  output  DataWidth  current top entry; 0 when empty.
- count_out  output  CountWidth  number of valid entries, 0..StackDepth.
- empty  output  1  count_out == 0.
- full  output  1  count_out == StackDepth.
- overflow  output  1  sticky: a push was dropped because the stack was full.
- underflow  output  1  sticky: a pop was issued while the stack was empty.
- high_water  output  CountWidth  present only with STACK_WATERMARK_EN.

Behaviour:
- Reset is synchronous and active-high on the clk edge; clock is clk.
- Reset values: count=0, empty=1, full=0, overflow=0, underflow=0, data_out=0, high_water=0.
- Memory contents are not cleared by reset; they are don't-care.
- Entry storage: slot count-1 is the top; the stack grows toward higher slot index.
- Operation decode each cycle, from {push,pop}, to NONE / PUSH / POP / REPLACE.
- NONE: no state change.
- PUSH, not full: mem[count] <= data_in; count <= count+1.
- PUSH, full: data is dropped, count is unchanged, overflow <= 1.
- POP, not empty: count <= count-1.
  - The popped value is the data_out presented during the pop cycle.
  - After the edge, data_out shows the new top.
- POP, empty: count stays 0, underflow <= 1.
- REPLACE (push && pop), not empty: mem[count-1] <= data_in; count is unchanged.
  - No error, including when full.
- REPLACE, empty: behaves as PUSH (count 0->1); no underflow.
- Latency:
  - data_out is combinational from storage and count.
  - A pushed or replaced value appears on data_out the cycle after the write edge.
  - count_out, empty and full are combinational from the count register.
- err_clear clears overflow and underflow at the next edge.
  - If an error event occurs in the same cycle, the set wins and the flag stays 1.
- Errors are sticky until err_clear or reset. They do not block further operations.
- Reset asserted mid-operation overrides push/pop in that cycle; count goes to 0.
- Count arithmetic is in CountWidth bits and never wraps: saturated by the full and empty guards.
- No combinational path from push/pop to data_out.

Optional Feature:
- Macro: STACK_WATERMARK_EN.
- Defined:
  - Adds the high_water output register, holding the maximum count_out reached since reset or err_clear.
  - Updated at the same edge as count: high_water <= max(high_water, next_count).
  - On err_clear, high_water <= next_count.
- Undefined: the high_water port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package stack_pkg:
  - stack_op_e enum {OP_NONE, OP_PUSH, OP_POP, OP_REPLACE}.
  - Function decode_op(push, pop) returning stack_op_e.
- Sub-module stack_mem:
  - Parameters StackDepth and DataWidth.
  - Ports: clk, we, waddr, wdata, raddr, rdata.
  - Combinational read, no reset.
- lifo_stack holds the op decode, count register, flags and watermark.

Test Plan (StackDepth=4, DataWidth=8):
- Reset, then push 0x11,0x22,0x33 -> count_out=3, data_out=0x33, empty=0, full=0; three pops return 0x33,0x22,0x11, then empty=1, data_out=0.
- Push 0xA0..0xA3 (full=1), then push 0xFF -> overflow=1, count_out=4, data_out=0xA3; pop -> data_out=0xA2.
- Pop on empty -> underflow=1, count_out=0; err_clear pulse -> underflow=0; err_clear with simultaneous empty pop -> underflow stays 1.
- Push 0x55, then push+pop 0x66 -> count_out=1, data_out=0x66; push+pop on empty after reset with 0x77 -> count_out=1, data_out=0x77, no underflow.
- Full stack plus replace 0x99 -> no overflow, data_out=0x99; reset asserted together with push -> count_out=0, empty=1, flags 0.
- With STACK_WATERMARK_EN: push 3, pop 2, push 1 -> high_water=3, count_out=2; err_clear -> high_water=2.
